// File: rtl/ixc_assign_arb_pkg.sv
// Shared types and constants for the ixc_assign_arb34 round-robin assign arbiter.
package ixc_assign_arb_pkg;

    localparam int ASSIGN_W = 34;   // default width of the shared assign bus
    localparam int MAX_REQ  = 8;    // largest supported requester count

    typedef enum logic [0:0] {
        IDLE = 1'b0,                // output register empty
        FULL = 1'b1                 // output register holds a beat
    } arb_state_t;

endpackage

// File: rtl/ixc_rr_pick.sv
// Rotating-priority picker: scans requests starting one past the pointer,
// wrapping modulo N, and returns a one-hot grant (all zero if no request).
module ixc_rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [PW-1:0] idx_s;
    logic          found_s;
    logic          hit_s;

    // First asserted request at (ptr+1), (ptr+2), ... mod N wins
    always_comb begin
        grant   = {N{1'b0}};
        idx_s   = {PW{1'b0}};
        found_s = 1'b0;
        hit_s   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx_s        = PW'((int'(ptr) + k) % N);
            hit_s        = ~found_s & req[idx_s];
            grant[idx_s] = grant[idx_s] | hit_s;
            found_s      = found_s | hit_s;
        end
    end

endmodule

// File: rtl/ixc_assign_arb34.sv
// N_REQ-to-1 round-robin arbiter feeding a registered 34-bit assign bus.
// One-cycle latency from accept to L; full throughput under l_ready=1.
// Optional feature: define IXC_ASSIGN_ARB_LOCK_EN to add req_lock, which keeps
// the grant with a requester until it completes a beat with req_lock=0.
module ixc_assign_arb34
    import ixc_assign_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = ASSIGN_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_data,
`ifdef IXC_ASSIGN_ARB_LOCK_EN
    input  logic [N_REQ-1:0]   req_lock,
`endif
    output logic [N_REQ-1:0]   req_ready,
    output logic [W-1:0]       L,
    output logic               l_valid,
    input  logic               l_ready,
    output logic [2:0]         l_src
);

    localparam int PW = $clog2(N_REQ);

    arb_state_t       state_r;
    arb_state_t       state_nxt_s;
    logic [PW-1:0]    last_grant_r;
    logic [PW-1:0]    win_idx_s;
    logic [N_REQ-1:0] pick_req_s;
    logic [N_REQ-1:0] grant_s;
    logic [W-1:0]     sel_data_s;
    logic             can_accept_s;
    logic             accept_s;

`ifdef IXC_ASSIGN_ARB_LOCK_EN
    logic             lock_r;
    logic [PW-1:0]    lock_owner_r;

    // While a locked sequence is open only its owner may compete
    always_comb begin
        pick_req_s = {N_REQ{1'b0}};
        if (lock_r) begin
            pick_req_s[lock_owner_r] = req_valid[lock_owner_r];
        end else begin
            pick_req_s = req_valid;
        end
    end

    // Lock bookkeeping: each accepted beat re-decides whether the lock stays
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_r       <= 1'b0;
            lock_owner_r <= {PW{1'b0}};
        end else if (accept_s) begin
            lock_r       <= req_lock[win_idx_s];
            lock_owner_r <= win_idx_s;
        end else begin
            lock_r       <= lock_r;
            lock_owner_r <= lock_owner_r;
        end
    end
`else
    // Pure round-robin: every valid requester competes
    always_comb begin
        pick_req_s = req_valid;
    end
`endif

    ixc_rr_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_pick (
        .req   (pick_req_s),
        .ptr   (last_grant_r),
        .grant (grant_s)
    );

    // Handshake: the winner is offered ready only when the output slot frees up
    always_comb begin
        can_accept_s = (state_r == IDLE) | l_ready;
        if (rst) begin
            req_ready = {N_REQ{1'b0}};
        end else if (can_accept_s) begin
            req_ready = grant_s;
        end else begin
            req_ready = {N_REQ{1'b0}};
        end
        accept_s = |req_ready;
    end

    // Winner index and data mux (grant is one-hot, so OR-combining is exact)
    always_comb begin
        win_idx_s  = {PW{1'b0}};
        sel_data_s = {W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            win_idx_s  = win_idx_s  | (grant_s[i] ? PW'(i) : {PW{1'b0}});
            sel_data_s = sel_data_s | (grant_s[i] ? req_data[i*W +: W] : {W{1'b0}});
        end
    end

    // Next-state: an accept always leaves the slot FULL; a drain without accept empties it
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = FULL;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FULL: begin
                if (accept_s) begin
                    state_nxt_s = FULL;
                end else if (l_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = FULL;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Output register and priority pointer; L and l_src hold while not accepting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            L            <= {W{1'b0}};
            l_src        <= 3'd0;
            l_valid      <= 1'b0;
            last_grant_r <= PW'(N_REQ - 1);
        end else if (accept_s) begin
            L            <= sel_data_s;
            l_src        <= 3'(win_idx_s);
            l_valid      <= 1'b1;
            last_grant_r <= win_idx_s;
        end else if (l_ready) begin
            l_valid      <= 1'b0;
        end else begin
            l_valid      <= l_valid;
        end
    end

endmodule

// File: tb/tb_ixc_assign_arb34.sv
// Self-checking bench for ixc_assign_arb34: directed scenarios with literal
// expectations, then randomized traffic compared against a behavioural model.
module tb_ixc_assign_arb34;

    localparam int N = 4;
    localparam int W = 34;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic           l_ready = 1'b0;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   L;
    logic           l_valid;
    logic [2:0]     l_src;
`ifdef IXC_ASSIGN_ARB_LOCK_EN
    logic [N-1:0]   req_lock = '0;
`endif

    int tests = 0;
    int fails = 0;

    // behavioural model state
    bit           mdl_full  = 1'b0;
    logic [W-1:0] mdl_L     = '0;
    int           mdl_src   = 0;
    int           mdl_last  = N - 1;
    bit           mdl_lock  = 1'b0;
    int           mdl_owner = 0;

    always #5 clk = ~clk;

    ixc_assign_arb34 #(.N_REQ(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
`ifdef IXC_ASSIGN_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .req_ready (req_ready),
        .L         (L),
        .l_valid   (l_valid),
        .l_ready   (l_ready),
        .l_src     (l_src)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Which requester should win this cycle (-1 if none), from the rules alone
    function automatic int exp_winner();
        if (mdl_full && !l_ready) return -1;
        if (mdl_lock) return req_valid[mdl_owner] ? mdl_owner : -1;
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (mdl_last + k) % N;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        g = exp_winner();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    // Model update on each edge; reset is asynchronous just like the design
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_full = 1'b0; mdl_L = '0; mdl_src = 0; mdl_last = N - 1;
            mdl_lock = 1'b0; mdl_owner = 0;
        end else begin
            int g;
            g = exp_winner();
            if (g >= 0) begin
                mdl_full = 1'b1;
                mdl_L    = req_data[g*W +: W];
                mdl_src  = g;
                mdl_last = g;
`ifdef IXC_ASSIGN_ARB_LOCK_EN
                mdl_lock  = req_lock[g];
                mdl_owner = g;
`endif
            end else if (l_ready) begin
                mdl_full = 1'b0;
            end
        end
    end

    // Compare process: every falling edge, DUT outputs against the model
    always @(negedge clk) begin
        if (rst) begin
            chk("ready_in_reset", 64'(req_ready), 64'(0));
        end else begin
            chk("req_ready", 64'(req_ready), 64'(exp_ready()));
            chk("l_valid", 64'(l_valid), 64'(mdl_full));
            if (mdl_full) begin
                chk("L", 64'(L), 64'(mdl_L));
                chk("l_src", 64'(l_src), 64'(mdl_src));
            end
        end
    end

    task automatic drive(input logic [N-1:0] v, input logic lr);
        @(posedge clk); #2;
        req_valid = v;
        l_ready   = lr;
    endtask

    task automatic at_neg();
        @(negedge clk); #1;
    endtask

    task automatic set_data(input int i, input logic [W-1:0] d);
        req_data[i*W +: W] = d;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1; req_valid = '0;
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    logic [N-1:0] seq29 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [W-1:0] dv [N];
    logic [63:0]  rnd;

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        at_neg();
        chk("rst_l_valid", 64'(l_valid), 64'(0));
        chk("rst_L", 64'(L), 64'(0));
        chk("rst_l_src", 64'(l_src), 64'(0));
        chk("rst_ready", 64'(req_ready), 64'(0));
        @(posedge clk); #2; rst = 1'b0;

        // single beat from requester 0
        set_data(0, 34'h0_0000_0ABC);
        drive(4'b0001, 1'b1);
        at_neg();
        chk("single_ready", 64'(req_ready), 64'(4'b0001));
        drive(4'b0000, 1'b1);
        at_neg();
        chk("single_L", 64'(L), 64'(34'h0_0000_0ABC));
        chk("single_l_valid", 64'(l_valid), 64'(1));
        chk("single_l_src", 64'(l_src), 64'(0));

        // all four valid, full throughput rotation
        do_reset();
        for (int i = 0; i < N; i++) begin
            dv[i] = 34'h2_0000_0000 | 34'(i * 17 + 1);
            set_data(i, dv[i]);
        end
        drive(4'b1111, 1'b1);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(posedge clk);
            at_neg();
            chk("rotate_ready", 64'(req_ready), 64'(seq29[c]));
            if (c > 0) chk("rotate_l_valid", 64'(l_valid), 64'(1));
        end

        // backpressure: hold for 5 cycles, then release
        drive(4'b1111, 1'b0);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(posedge clk);
            at_neg();
            chk("stall_ready", 64'(req_ready), 64'(0));
            chk("stall_L", 64'(L), 64'(dv[0]));
            chk("stall_l_src", 64'(l_src), 64'(0));
            chk("stall_l_valid", 64'(l_valid), 64'(1));
        end
        drive(4'b1111, 1'b1);
        at_neg();
        chk("release_ready", 64'(req_ready), 64'(4'b0010));
        @(posedge clk);
        at_neg();
        chk("release_L", 64'(L), 64'(dv[1]));
        chk("release_l_src", 64'(l_src), 64'(1));

        // full 34-bit payload
        do_reset();
        set_data(1, 34'h3_FFFF_FFFF);
        drive(4'b0010, 1'b1);
        at_neg();
        chk("wide_ready", 64'(req_ready), 64'(4'b0010));
        drive(4'b0000, 1'b1);
        at_neg();
        chk("wide_L", 64'(L), 64'(34'h3_FFFF_FFFF));
        chk("wide_l_src", 64'(l_src), 64'(1));

        // asynchronous reset mid-stream
        drive(4'b1111, 1'b1);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_l_valid", 64'(l_valid), 64'(0));
        chk("async_L", 64'(L), 64'(0));
        chk("async_ready", 64'(req_ready), 64'(0));
        @(posedge clk); #2; rst = 1'b0;
        at_neg();
        chk("after_rst_ready", 64'(req_ready), 64'(4'b0001));

`ifdef IXC_ASSIGN_ARB_LOCK_EN
        // locked burst from requester 2
        do_reset();
        drive(4'b0010, 1'b1);
        at_neg();
        chk("lock_pre", 64'(req_ready), 64'(4'b0010));
        drive(4'b1111, 1'b1); req_lock = 4'b0100;
        at_neg();
        chk("lock_g1", 64'(req_ready), 64'(4'b0100));
        @(posedge clk); #2;
        at_neg();
        chk("lock_g2", 64'(req_ready), 64'(4'b0100));
        @(posedge clk); #2; req_lock = 4'b0000;
        at_neg();
        chk("lock_g3", 64'(req_ready), 64'(4'b0100));
        @(posedge clk); #2;
        at_neg();
        chk("lock_after", 64'(req_ready), 64'(4'b1000));
`endif

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #2;
            rst       = ($urandom_range(299, 0) == 0);
            req_valid = N'($urandom());
            l_ready   = ($urandom_range(3, 0) != 0);
            for (int i = 0; i < N; i++) begin
                rnd = {$urandom(), $urandom()};
                set_data(i, rnd[W-1:0]);
            end
`ifdef IXC_ASSIGN_ARB_LOCK_EN
            req_lock = ($urandom_range(3, 0) == 0) ? N'($urandom()) : '0;
`endif
        end
        @(posedge clk); #2; rst = 1'b0; req_valid = '0;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
